// File: rtl/axi_mm2s_io.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axi_mm2s_io
//  Purpose  : AXI4 memory-to-stream reader. Splits the read into bursts,
//             realigns unaligned data and emits it packed on M_AXIS.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_mm2s_io #(
   parameter int C_AXI_WIDTH      = 128,
   parameter int C_AXI_ADDR_WIDTH = 64,
   parameter int C_AXI_MAX_BURST  = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        busy,
   output logic [1:0]                  response,
   input  logic                        trigger,
   input  logic [C_AXI_ADDR_WIDTH-1:0] start_addr,
   input  logic [15:0]                 bytes_to_read,
   output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [C_AXI_WIDTH-1:0]      m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   output logic [C_AXI_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXI_WIDTH/8-1:0]    m_axis_tstrb,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready
);

   localparam int c_NB = C_AXI_WIDTH / 8;
   localparam int c_OW = $clog2(c_NB);

   typedef enum logic [1:0] {
      AR_IDLE = 2'd0,
      AR_CALC = 2'd1,
      AR_ADDR = 2'd2,
      AR_DONE = 2'd3
   } ar_state_t;

   ar_state_t                   r_state;
   logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
   logic [16:0]                 r_ar_rem;
   logic [C_AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]                  r_arlen;
   logic [2:0]                  r_arsize;
   logic                        r_arvalid;

   logic                        r_busy;
   logic [1:0]                  r_response;
   logic [c_OW-1:0]             r_offset;
   logic [c_OW-1:0]             r_last_idx;
   logic [16:0]                 r_r_rem;
   logic [16:0]                 r_o_rem;
   logic                        r_first;
   logic [C_AXI_WIDTH-1:0]      r_hold;
   logic [C_AXI_WIDTH-1:0]      r_tdata;
   logic [c_NB-1:0]             r_tstrb;
   logic                        r_tlast;
   logic                        r_tvalid;

   logic                        w_start;
   logic [16:0]                 w_r_beats;
   logic [16:0]                 w_o_beats;
   logic [12:0]                 w_to4k;
   logic [16:0]                 w_4k_m1;
   logic [16:0]                 w_rem_m1;
   logic [7:0]                  w_arlen;
   logic [8:0]                  w_burst_beats;
   logic                        w_rready;
   logic                        w_rhs;
   logic                        w_out_free;
   logic                        w_flush;
   logic                        w_emit;
   logic                        w_is_last;
   logic [2*C_AXI_WIDTH-1:0]    w_cat;
   logic [C_AXI_WIDTH-1:0]      w_aligned;
   logic [C_AXI_WIDTH-1:0]      w_word;
   logic [c_NB-1:0]             w_strb;
   logic [C_AXI_WIDTH-1:0]      w_mask;
   logic                        w_unused;

   // rlast is deliberately ignored: R beats are counted instead
   assign w_unused = m_axi_rlast;

   assign w_start   = trigger & ~r_busy;
   assign w_r_beats = ({1'b0, bytes_to_read} + 17'(start_addr[c_OW-1:0]) + 17'(c_NB)) >> c_OW;
   assign w_o_beats = ({1'b0, bytes_to_read} + 17'(c_NB)) >> c_OW;

   assign w_to4k        = (13'h1000 - {1'b0, r_addr[11:0]}) >> c_OW;
   assign w_4k_m1       = {4'b0, w_to4k} - 17'd1;
   assign w_rem_m1      = r_ar_rem - 17'd1;
   assign w_burst_beats = {1'b0, r_arlen} + 9'd1;

   always_comb begin
      w_arlen = 8'(C_AXI_MAX_BURST);
      if (w_rem_m1 < 17'(C_AXI_MAX_BURST))
         w_arlen = w_rem_m1[7:0];
      if (w_4k_m1 < {9'b0, w_arlen})
         w_arlen = w_4k_m1[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= AR_IDLE;
         r_addr    <= '0;
         r_ar_rem  <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arvalid <= 1'b0;
      end else begin
         case (r_state)
            AR_IDLE: ;
            AR_CALC: begin
               r_araddr  <= r_addr;
               r_arlen   <= w_arlen;
               r_arsize  <= 3'(c_OW);
               r_arvalid <= 1'b1;
               r_state   <= AR_ADDR;
            end
            AR_ADDR: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_addr    <= r_addr + (C_AXI_ADDR_WIDTH'(w_burst_beats) << c_OW);
                  r_ar_rem  <= r_ar_rem - {8'b0, w_burst_beats};
                  r_state   <= (r_ar_rem == {8'b0, w_burst_beats}) ? AR_DONE : AR_CALC;
               end
            end
            AR_DONE: begin
               if (!r_busy)
                  r_state <= AR_IDLE;
            end
            default: r_state <= AR_IDLE;
         endcase
         if (w_start) begin
            r_addr   <= {start_addr[C_AXI_ADDR_WIDTH-1:c_OW], {c_OW{1'b0}}};
            r_ar_rem <= w_r_beats;
            r_state  <= AR_CALC;
         end
      end
   end

   assign w_out_free = ~r_tvalid | m_axis_tready;
   assign w_rready   = r_busy & (r_r_rem != 17'd0) & w_out_free;
   assign w_rhs      = m_axi_rvalid & w_rready;
   // Flush drains the held word once every R beat is in but an output beat remains
   assign w_flush    = r_busy & (r_r_rem == 17'd0) & (r_o_rem != 17'd0) & w_out_free;
   assign w_emit     = (w_rhs & ((r_offset == '0) | ~r_first)) | w_flush;
   assign w_is_last  = (r_o_rem == 17'd1);

   assign w_cat     = {(w_rhs ? m_axi_rdata : {C_AXI_WIDTH{1'b0}}), r_hold};
   assign w_aligned = C_AXI_WIDTH'(w_cat >> {r_offset, 3'b000});
   assign w_word    = (r_offset == '0) ? m_axi_rdata : w_aligned;

   always_comb begin
      w_strb = '1;
      w_mask = '0;
      for (int j = 0; j < c_NB; j++) begin
         if (w_is_last && (c_OW'(j) > r_last_idx))
            w_strb[j] = 1'b0;
         w_mask[8*j +: 8] = {8{w_strb[j]}};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_response <= 2'd0;
         r_offset   <= '0;
         r_last_idx <= '0;
         r_r_rem    <= '0;
         r_o_rem    <= '0;
         r_first    <= 1'b0;
         r_hold     <= '0;
         r_tdata    <= '0;
         r_tstrb    <= '0;
         r_tlast    <= 1'b0;
         r_tvalid   <= 1'b0;
      end else begin
         if (w_start) begin
            r_busy     <= 1'b1;
            r_response <= 2'd0;
            r_offset   <= start_addr[c_OW-1:0];
            r_last_idx <= bytes_to_read[c_OW-1:0];
            r_r_rem    <= w_r_beats;
            r_o_rem    <= w_o_beats;
            r_first    <= 1'b1;
         end
         if (w_rhs) begin
            r_r_rem <= r_r_rem - 17'd1;
            r_first <= 1'b0;
            r_hold  <= m_axi_rdata;
            if (!r_response[1])
               r_response <= m_axi_rresp[1] ? m_axi_rresp : 2'd1;
         end
         if (r_tvalid && m_axis_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            if (r_tlast)
               r_busy <= 1'b0;
         end
         if (w_emit) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_word & w_mask;
            r_tstrb  <= w_strb;
            r_tlast  <= w_is_last;
            r_o_rem  <= r_o_rem - 17'd1;
         end
      end
   end

   assign busy          = r_busy;
   assign response      = r_response;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arsize  = r_arsize;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = w_rready;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tstrb  = r_tstrb;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: doc/axi_mm2s_io.md
Name: axi_mm2s_io

Overview:
- Memory-to-stream reader; the read-side counterpart of the stream-to-memory writer used by the DMA cores.
- On trigger, reads bytes_to_read+1 bytes from start_addr over AXI4 AR/R. Bursts are split at C_AXI_MAX_BURST, 4 KiB boundaries and remaining length.
- Realigns unaligned data and emits it on M_AXIS, packed from byte 0, with tlast on the final beat.

Parameters:
C_AXI_WIDTH, 128, data width in bits (power of 2, ≥32); W = C_AXI_WIDTH/8 bytes, O = log2(W).
C_AXI_ADDR_WIDTH, 64, address width.
C_AXI_MAX_BURST, 255, maximum arlen value (0..255).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
busy  out  1  transfer in progress
response  out  2  0 none, 1 OK/EXOKAY, 2 SLVERR, 3 DECERR
trigger  in  1  start pulse, sampled when ~busy
start_addr  in  C_AXI_ADDR_WIDTH  first byte address
bytes_to_read  in  16  byte count minus one
m_axi_araddr/arlen/arsize/arvalid/arready  out/out/out/out/in  ADDR/8/3/1/1  AR channel
m_axi_rdata/rresp/rlast/rvalid/rready  in/in/in/in/out  C_AXI_WIDTH/2/1/1/1  R channel
m_axis_tdata/tstrb/tlast/tvalid/tready  out/out/out/out/in  C_AXI_WIDTH/W/1/1/1  output stream

Behaviour:
- Reset (rst_n=0 at a clk edge): busy=0, response=0, arvalid=0, araddr=0, arlen=0, arsize=0, rready=0, m_axis_tvalid=0, tlast=0, tdata=0, tstrb=0, all FSMs idle.
- Reset mid-transfer aborts immediately. Outstanding AXI bursts are abandoned; the slave must be reset alongside.
- Trigger with ~busy:
  - Latch N=bytes_to_read+1, offset=start_addr[O-1:0].
  - Compute total R beats = ceil((offset+N)/W) and output beats = ceil(N/W).
  - Clear response to 0; busy=1 next cycle.
- Trigger while busy is ignored.
- AR FSM:
  - IDLE→CALC on accepted trigger.
  - CALC computes the burst length, arlen = min(C_AXI_MAX_BURST, remaining R beats−1, beats to next 4 KiB boundary−1) → ADDR.
  - ADDR: araddr = current address with low O bits cleared, arsize=O always; arvalid=1 holds until arready.
  - On handshake: address += (arlen+1)·W; remaining −= arlen+1; → CALC if remaining>0, else DONE.
  - DONE→IDLE when busy drops.
  - arvalid first rises 2 cycles after the trigger cycle.
- R/realign path:
  - Two-word shift register. Output word k = bytes [offset+kW, offset+(k+1)W) of the concatenated R data.
  - offset≠0: the first R beat is only loaded and produces no output. Each later R beat yields one output beat.
  - If output beats = R beats (offset≠0), one flush beat is emitted from the held word after the last R beat, with the upper bytes zero.
  - offset=0: each R beat passes straight through.
  - rready = busy & R beats outstanding & (output register empty or tready).
  - No data loss under any tready pattern; rready drops the same cycle the output register is full and tready=0.
  - R beats are counted; rlast is not used for control.
- Output:
  - Registered M_AXIS. tvalid held until tready.
  - tstrb=all ones except on the last beat, which has the low ((N−1) mod W)+1 bits set.
  - tlast only on beat ceil(N/W). Unused tdata bytes are zero.
- response: on each R handshake while response∈{0,1}, rresp 00/01→1, 10→2, 11→3. Once response is 2 or 3 it holds until the next trigger.
- busy falls the cycle after both the tlast handshake and the final R handshake have occurred.
- Address arithmetic wraps modulo 2^C_AXI_ADDR_WIDTH. Byte counters are 17 bits wide (N up to 65536).

Test Plan:
1. W=16, start_addr=0x1000, bytes_to_read=63 → one AR (0x1000, arlen=3, arsize=4). Four output beats equal to R data, tstrb=0xFFFF, tlast on beat 4, response=1, busy falls.
2. start_addr=0x1003, bytes_to_read=15 → AR 0x1000 arlen=1. One output beat = R0[bytes 3..15] ‖ R1[bytes 0..2], tstrb=0xFFFF, tlast=1.
3. start_addr=0x0FF0, bytes_to_read=31 → two ARs (0x0FF0 arlen=0, then 0x1000 arlen=0). Two output beats, tlast on the 2nd.
4. start_addr=0x0, bytes_to_read=0xFFFF → 16 ARs at 0x0,0x1000…0xF000, each arlen=255. Exactly 4096 output beats. With C_AXI_MAX_BURST=15 → 256 ARs of arlen=15.
5. start_addr=0x5, bytes_to_read=19, tready toggling 1-of-3 cycles, rresp=10 on R beat 1 then 11 → output bytes match memory 0x5..0x18. Last tstrb=0x000F, response=2 held.
6. Assert rst_n=0 mid-burst, then a new trigger → all outputs at reset values the next cycle. The new transfer completes correctly, response=1.
